// File: rtl/ra_64x72_bist_ctl.sv
// ---------------------------------------------------------------------------
// ra_64x72_bist_ctl
//
// March C- self-test sequencer for the 64x72 2r1w array wrapper. It walks the
// six march elements, drives the wrapper's write port and both read ports
// from registers, and compares the returned read data against the value each
// read expects. It reports pass/fail, a saturating count of failing compare
// cycles, and the location of the first failing compare.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   start               pulse; accepted only while idle
//   busy                high from start acceptance through the done cycle
//   done                one-cycle pulse at end of test
//   pass                result, valid from done until the next accepted start
//   fail_cnt            saturating count of failing compare cycles
//   fail_adr/elem/port  address, march element and port mask ([0]=port 0,
//                       [1]=port 1) of the first failing compare
//   rd_enb_*, rd_adr_*  read port controls (both ports always read together)
//   rd_dat_*            read data, valid RD_LAT cycles after issue
//   wr_enb_0, wr_adr_0,
//   wr_dat_0            write port controls
// ---------------------------------------------------------------------------
module ra_64x72_bist_ctl #(
    parameter int LATCHRD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [0:7]  fail_cnt,
    output logic [0:5]  fail_adr,
    output logic [0:2]  fail_elem,
    output logic [0:1]  fail_port,
    output logic        rd_enb_0,
    output logic        rd_enb_1,
    output logic [0:5]  rd_adr_0,
    output logic [0:5]  rd_adr_1,
    input  logic [0:71] rd_dat_0,
    input  logic [0:71] rd_dat_1,
    output logic        wr_enb_0,
    output logic [0:5]  wr_adr_0,
    output logic [0:71] wr_dat_0
);

    localparam int RD_LAT = 1 + LATCHRD;
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] drain_cnt;

    // Sequence position of the NEXT operation to issue. elem runs 0..5 and
    // parks at 6 once the last M5 read has been issued.
    logic [2:0] elem;
    logic [5:0] step;
    logic       phase;      // M1-M4 only: 0 = read half, 1 = write half

    // Side information travelling with the read currently on the ports.
    logic       iss_exp;
    logic [2:0] iss_elem;

    // Read-return pipe: one stage per cycle of read latency.
    logic       pipe_vld  [RD_LAT];
    logic       pipe_exp  [RD_LAT];
    logic [5:0] pipe_adr  [RD_LAT];
    logic [2:0] pipe_elem [RD_LAT];

    logic       accept;
    logic       seq_end;
    logic       issue;
    logic       op_rd;
    logic       op_wr;
    logic       op_bit;
    logic [5:0] op_adr;

    logic       cmp_vld;
    logic       mis_0;
    logic       mis_1;
    logic       cmp_fail;
    logic [7:0] fail_cnt_nxt;

    assign accept  = (state == ST_IDLE) && start;
    assign seq_end = (elem == 3'd6);
    // The start-accepting edge already loads the first M0 write.
    assign issue   = accept || ((state == ST_RUN) && !seq_end);

    // Decode the operation at the current sequence position.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        op_rd  = 1'b0;
        op_wr  = 1'b0;
        op_bit = 1'b0;
        op_adr = (elem >= 3'd3) ? (6'd63 - step) : step;
        case (elem)
            3'd0: begin
                op_wr  = 1'b1;
                op_bit = 1'b0;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (!phase) begin
                    op_rd  = 1'b1;
                    op_bit = (elem == 3'd2) || (elem == 3'd4);
                end else begin
                    op_wr  = 1'b1;
                    op_bit = (elem == 3'd1) || (elem == 3'd3);
                end
            end
            3'd5: begin
                op_rd  = 1'b1;
                op_bit = 1'b0;
            end
            default: begin
                op_adr = 6'd0;
            end
        endcase
    end

    // Compare stage: data and its expectation line up at the pipe tail.
    always_comb begin
        cmp_vld  = pipe_vld[RD_LAT-1];
        mis_0    = cmp_vld && (rd_dat_0 != {72{pipe_exp[RD_LAT-1]}});
        mis_1    = cmp_vld && (rd_dat_1 != {72{pipe_exp[RD_LAT-1]}});
        cmp_fail = mis_0 || mis_1;
        fail_cnt_nxt = fail_cnt;
        if (cmp_fail && (fail_cnt != 8'hFF)) begin
            fail_cnt_nxt = fail_cnt + 8'd1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 2'd0;
            elem      <= 3'd0;
            step      <= 6'd0;
            phase     <= 1'b0;
            iss_exp   <= 1'b0;
            iss_elem  <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_cnt  <= 8'd0;
            fail_adr  <= 6'd0;
            fail_elem <= 3'd0;
            fail_port <= 2'b00;
            rd_enb_0  <= 1'b0;
            rd_enb_1  <= 1'b0;
            rd_adr_0  <= 6'd0;
            rd_adr_1  <= 6'd0;
            wr_enb_0  <= 1'b0;
            wr_adr_0  <= 6'd0;
            wr_dat_0  <= 72'h0;
        end else begin
            done <= 1'b0;

            // Port registers and sequence position. Idle cycles drive zeros
            // and park the sequence at its origin for the next test.
            if (issue) begin
                rd_enb_0 <= op_rd;
                rd_enb_1 <= op_rd;
                rd_adr_0 <= op_rd ? op_adr : 6'd0;
                rd_adr_1 <= op_rd ? op_adr : 6'd0;
                wr_enb_0 <= op_wr;
                wr_adr_0 <= op_wr ? op_adr : 6'd0;
                wr_dat_0 <= op_wr ? {72{op_bit}} : 72'h0;
                iss_exp  <= op_rd && op_bit;
                iss_elem <= op_rd ? elem : 3'd0;
                if ((elem >= 3'd1) && (elem <= 3'd4) && !phase) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (step == 6'd63) begin
                        step <= 6'd0;
                        elem <= elem + 3'd1;
                    end else begin
                        step <= step + 6'd1;
                    end
                end
            end else begin
                rd_enb_0 <= 1'b0;
                rd_enb_1 <= 1'b0;
                rd_adr_0 <= 6'd0;
                rd_adr_1 <= 6'd0;
                wr_enb_0 <= 1'b0;
                wr_adr_0 <= 6'd0;
                wr_dat_0 <= 72'h0;
                iss_exp  <= 1'b0;
                iss_elem <= 3'd0;
                elem     <= 3'd0;
                step     <= 6'd0;
                phase    <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (seq_end) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        // The final M5 compare retires on this same edge.
                        pass  <= (fail_cnt_nxt == 8'd0);
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (accept) begin
                pass      <= 1'b0;
                fail_cnt  <= 8'd0;
                fail_adr  <= 6'd0;
                fail_elem <= 3'd0;
                fail_port <= 2'b00;
            end else begin
                fail_cnt <= fail_cnt_nxt;
                // fail_cnt never wraps, so zero identifies the first failure.
                if (cmp_fail && (fail_cnt == 8'd0)) begin
                    fail_adr  <= pipe_adr[RD_LAT-1];
                    fail_elem <= pipe_elem[RD_LAT-1];
                    fail_port <= {mis_0, mis_1};
                end
            end
        end
    end

    // NOTE: the pipe is a handful of flops, not a RAM, so it is reset; this
    // keeps reads in flight at reset from producing phantom compares.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_exp[i]  <= 1'b0;
                pipe_adr[i]  <= 6'd0;
                pipe_elem[i] <= 3'd0;
            end
        end else begin
            pipe_vld[0]  <= rd_enb_0;
            pipe_exp[0]  <= iss_exp;
            pipe_adr[0]  <= rd_adr_0;
            pipe_elem[0] <= iss_elem;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_adr[i]  <= pipe_adr[i-1];
                pipe_elem[i] <= pipe_elem[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ra_64x72_bist_ctl.sv
// ---------------------------------------------------------------------------
// tb_ra_64x72_bist_ctl
//
// Two sequencers (LATCHRD=0 on index 0, LATCHRD=1 on index 1), each attached
// to a behavioural 64x72 array with a configurable fault. A reference walk of
// the March C- table yields the expected port activity for every cycle and
// the expected result (count, first failing location, pass).
// ---------------------------------------------------------------------------
module tb_ra_64x72_bist_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [2];
    logic        start     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [7:0]  fail_cnt  [2];
    logic [5:0]  fail_adr  [2];
    logic [2:0]  fail_elem [2];
    logic [1:0]  fail_port [2];
    logic        rd_enb_0  [2];
    logic        rd_enb_1  [2];
    logic [5:0]  rd_adr_0  [2];
    logic [5:0]  rd_adr_1  [2];
    logic [71:0] rd_dat_0  [2];
    logic [71:0] rd_dat_1  [2];
    logic        wr_enb_0  [2];
    logic [5:0]  wr_adr_0  [2];
    logic [71:0] wr_dat_0  [2];

    ra_64x72_bist_ctl #(.LATCHRD(0)) dut_l0 (
        .clk(clk), .reset(reset[0]), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_cnt(fail_cnt[0]), .fail_adr(fail_adr[0]),
        .fail_elem(fail_elem[0]), .fail_port(fail_port[0]),
        .rd_enb_0(rd_enb_0[0]), .rd_enb_1(rd_enb_1[0]),
        .rd_adr_0(rd_adr_0[0]), .rd_adr_1(rd_adr_1[0]),
        .rd_dat_0(rd_dat_0[0]), .rd_dat_1(rd_dat_1[0]),
        .wr_enb_0(wr_enb_0[0]), .wr_adr_0(wr_adr_0[0]), .wr_dat_0(wr_dat_0[0])
    );

    ra_64x72_bist_ctl #(.LATCHRD(1)) dut_l1 (
        .clk(clk), .reset(reset[1]), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_cnt(fail_cnt[1]), .fail_adr(fail_adr[1]),
        .fail_elem(fail_elem[1]), .fail_port(fail_port[1]),
        .rd_enb_0(rd_enb_0[1]), .rd_enb_1(rd_enb_1[1]),
        .rd_adr_0(rd_adr_0[1]), .rd_adr_1(rd_adr_1[1]),
        .rd_dat_0(rd_dat_0[1]), .rd_dat_1(rd_dat_1[1]),
        .wr_enb_0(wr_enb_0[1]), .wr_adr_0(wr_adr_0[1]), .wr_dat_0(wr_dat_0[1])
    );

    // ---------------- fault definition (shared by array and reference) ----
    // kind 0: none; 1: bit stuck at f_val on both ports at f_adr;
    // 2: port 1 only, bit forced to f_val at f_adr; 3: port 0 returns ~data.
    int   f_kind;
    int   f_adr;
    int   f_bit;
    logic f_val;

    function automatic logic [71:0] fault_read(int port, int adr, logic [71:0] word);
        logic [71:0] w;
        w = word;
        case (f_kind)
            1: if (adr == f_adr) w[f_bit] = f_val;
            2: if ((port == 1) && (adr == f_adr)) w[f_bit] = f_val;
            3: if (port == 0) w = ~w;
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- behavioural array, one per sequencer -----------------
    logic [71:0] mem  [2][64];
    logic [71:0] s1_0 [2];
    logic [71:0] s1_1 [2];
    logic [71:0] s2_0 [2];
    logic [71:0] s2_1 [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_enb_0[i]) mem[i][wr_adr_0[i]] <= wr_dat_0[i];
            s1_0[i] <= rd_enb_0[i] ? fault_read(0, int'(rd_adr_0[i]), mem[i][rd_adr_0[i]]) : 72'h0;
            s1_1[i] <= rd_enb_1[i] ? fault_read(1, int'(rd_adr_1[i]), mem[i][rd_adr_1[i]]) : 72'h0;
            s2_0[i] <= s1_0[i];
            s2_1[i] <= s1_1[i];
        end
    end

    always_comb begin
        rd_dat_0[0] = s1_0[0];
        rd_dat_1[0] = s1_1[0];
        rd_dat_0[1] = s2_0[1];
        rd_dat_1[1] = s2_1[1];
    end

    // ---------------- checking -------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] obs(int i);
        logic [127:0] v;
        v = {busy[i], done[i], rd_enb_0[i], rd_enb_1[i], wr_enb_0[i],
             rd_adr_0[i], rd_adr_1[i], wr_adr_0[i], wr_dat_0[i]};
        return v;
    endfunction

    function automatic logic [127:0] stat(int i);
        logic [127:0] v;
        v = {pass[i], fail_cnt[i], fail_adr[i], fail_elem[i], fail_port[i]};
        return v;
    endfunction

    // ---------------- reference model ------------------------------------
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [5:0]  adr;
        logic [71:0] dat;
    } op_t;

    op_t        exp_ops[$];
    int         r_cnt;
    int         r_adr;
    int         r_elem;
    logic [1:0] r_port;
    logic       r_pass;

    // March C-: direction and up to two (read?, value) operations per element.
    int e_down [6] = '{0, 0, 0, 1, 1, 1};
    int e_nops [6] = '{1, 2, 2, 2, 2, 1};
    int e_rd   [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    int e_val  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    task automatic build_ref();
        logic [71:0] m [64];
        logic [71:0] w;
        logic        mis0;
        logic        mis1;
        int          a;
        op_t         op;
        exp_ops.delete();
        r_cnt = 0; r_adr = 0; r_elem = 0; r_port = 2'b00;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 64; k++) begin
                a = (e_down[e] != 0) ? 63 - k : k;
                for (int j = 0; j < e_nops[e]; j++) begin
                    w = (e_val[e][j] != 0) ? {72{1'b1}} : 72'h0;
                    op.adr = 6'(a);
                    if (e_rd[e][j] != 0) begin
                        op.rd = 1'b1; op.wr = 1'b0; op.dat = 72'h0;
                        mis0 = (fault_read(0, a, m[a]) != w);
                        mis1 = (fault_read(1, a, m[a]) != w);
                        if (mis0 || mis1) begin
                            if (r_cnt == 0) begin
                                r_adr = a; r_elem = e; r_port = {mis0, mis1};
                            end
                            if (r_cnt < 255) r_cnt++;
                        end
                    end else begin
                        op.rd = 1'b0; op.wr = 1'b1; op.dat = w;
                        m[a] = w;
                    end
                    exp_ops.push_back(op);
                end
            end
        end
        r_pass = (r_cnt == 0);
    endtask

    // ---------------- one test run ---------------------------------------
    // Entered at a negedge; returns at the negedge of the cycle after done
    // (or after the reset check), so the next run can start in that cycle.
    task automatic run_test(input int i, input string tag, input int st_a, input int st_b, input int reset_at);
        int          done_cyc;
        op_t         op;
        logic [127:0] expv;
        done_cyc = 642 + i;            // 641 + RD_LAT, RD_LAT = 1 + LATCHRD
        build_ref();
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        for (int n = 1; n <= done_cyc; n++) begin
            if (n > 1) @(negedge clk);
            op = (n <= 640) ? exp_ops[n-1] : '0;
            expv = {1'b1, (n == done_cyc), op.rd, op.rd, op.wr,
                    op.rd ? op.adr : 6'd0, op.rd ? op.adr : 6'd0,
                    op.wr ? op.adr : 6'd0, op.dat};
            check($sformatf("%s cyc%0d ports", tag, n), obs(i), expv);
            if (n == done_cyc) begin
                check($sformatf("%s result", tag), stat(i),
                      {r_pass, 8'(r_cnt), 6'(r_adr), 3'(r_elem), r_port});
            end
            start[i] = ((n == st_a) || (n == st_b));
            if (n == reset_at) begin
                reset[i] = 1'b1;
                @(negedge clk);
                check($sformatf("%s reset ports", tag), obs(i), '0);
                check($sformatf("%s reset status", tag), stat(i), '0);
                reset[i] = 1'b0;
                return;
            end
        end
        start[i] = 1'b0;
        @(negedge clk);
        check($sformatf("%s after done", tag), obs(i), '0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            start[i] = 1'b0;
        end
        f_kind = 0; f_adr = 0; f_bit = 0; f_val = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset ports %0d", i), obs(i), '0);
            check($sformatf("reset status %0d", i), stat(i), '0);
        end
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);

        // LATCHRD=1 directed cases
        f_kind = 0;
        run_test(1, "l1_clean", 0, 0, 0);
        f_kind = 1; f_adr = 17; f_bit = 40; f_val = 1'b0;
        run_test(1, "l1_sa0_17", 0, 0, 0);
        f_kind = 2; f_adr = 5; f_bit = 0; f_val = 1'b1;
        run_test(1, "l1_p1_5", 0, 0, 0);
        f_kind = 3;
        run_test(1, "l1_inv0", 0, 0, 0);
        f_kind = 0;
        run_test(1, "l1_start_ign", 10, 500, 0);
        run_test(1, "l1_reset", 0, 0, 300);
        run_test(1, "l1_after_rst", 0, 0, 0);

        // LATCHRD=0 directed cases
        run_test(0, "l0_clean", 0, 0, 0);
        f_kind = 1; f_adr = 17; f_bit = 40; f_val = 1'b0;
        run_test(0, "l0_sa0_17", 0, 0, 0);

        // Randomized faults on either sequencer
        for (int t = 0; t < 6; t++) begin
            int inst;
            inst   = int'($urandom_range(1, 0));
            f_kind = int'($urandom_range(3, 0));
            f_adr  = int'($urandom_range(63, 0));
            f_bit  = int'($urandom_range(71, 0));
            f_val  = 1'($urandom_range(1, 0));
            repeat (int'($urandom_range(3, 0))) @(negedge clk);
            run_test(inst, $sformatf("rnd%0d_i%0d_k%0d_a%0d_b%0d_v%0d", t, inst, f_kind, f_adr, f_bit, f_val), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
